cbd_sample_ctrl: RTL and testbench

//  Sequencer for eta=2 centered-binomial sampling (Kyber-768-90s secret/error vectors).
//  Per polynomial: issues a PRF request with an incrementing nonce, consumes 128 PRF bytes
//  (valid/ready), converts each nibble to one coefficient and writes 256 coeffs/poly to poly RAM.

---
 rtl/kyber_pkg.sv | 9 +
 rtl/cbd_coef_unit.sv | 25 ++
 rtl/cbd_sample_ctrl.sv | 137 +++++++++++++
 tb/tb_cbd_sample_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber constants, coefficient type and CBD sequencer states
package kyber_pkg;
    localparam int KYBER_N    = 256;
    localparam int KYBER_Q    = 3329;
    localparam int KYBER_ETA1 = 2;
    localparam int CBD_BYTES  = 64 * KYBER_ETA1;
    typedef logic [11:0] coef_t;
    typedef enum logic [2:0] {IDLE, REQ, STREAM, NEXT, DONE} cbd_state_e;
endpackage

// File: rtl/cbd_coef_unit.sv
// cbd_coef_unit: nibble -> eta=2 CBD coefficient; CBD_MODQ_EN selects mod-Q output, else two's complement
module cbd_coef_unit #(
    parameter int Q      = 3329,
    parameter int COEF_W = 12
) (
    input  logic [3:0]        nib_i,
    output logic [COEF_W-1:0] coef_o
);
`ifdef CBD_MODQ_EN
    localparam bit MODQ = 1'b1;
`else
    localparam bit MODQ = 1'b0;
`endif
    logic [1:0]        pos, neg;
    logic [2:0]        c;
    logic [COEF_W-1:0] se;
    // Centered binomial difference, sign-extended, optionally folded into [0,Q-1]
    always_comb begin
        pos    = {1'b0, nib_i[0]} + {1'b0, nib_i[1]};
        neg    = {1'b0, nib_i[2]} + {1'b0, nib_i[3]};
        c      = {1'b0, pos} - {1'b0, neg};
        se     = {{(COEF_W-3){c[2]}}, c};
        coef_o = (MODQ && c[2]) ? se + COEF_W'(Q) : se;
    end
endmodule

// File: rtl/cbd_sample_ctrl.sv
// cbd_sample_ctrl: PRF-driven eta=2 CBD sampler writing 256 coeffs per poly; option macro CBD_MODQ_EN
module cbd_sample_ctrl
    import kyber_pkg::*;
#(
    parameter int MAX_POLY = 6,
    parameter int Q        = KYBER_Q,
    parameter int COEF_W   = 12
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [7:0]                    nonce_base_i,
    input  logic [$clog2(MAX_POLY+1)-1:0] num_poly_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          prf_req_o,
    output logic [7:0]                    prf_nonce_o,
    input  logic                          prf_ack_i,
    input  logic                          byte_valid_i,
    input  logic [7:0]                    byte_data_i,
    output logic                          byte_ready_o,
    output logic                          coef_we_o,
    output logic [$clog2(MAX_POLY)-1:0]   coef_poly_o,
    output logic [$clog2(KYBER_N)-1:0]    coef_addr_o,
    output logic [COEF_W-1:0]             coef_data_o
);
    localparam int NW = $clog2(MAX_POLY+1);
    localparam int PW = $clog2(MAX_POLY);
    localparam int AW = $clog2(KYBER_N);

    cbd_state_e        state_q, state_d;
    logic [NW-1:0]     num_q, num_d;
    logic [PW-1:0]     poly_q, poly_d, cpoly_q, cpoly_d;
    logic [7:0]        nonce_q, nonce_d, cnt_q, cnt_d;
    logic              hi_q, hi_d, we_q, we_d;
    logic [3:0]        nib_q, nib_d, nib;
    logic [AW-1:0]     addr_q, addr_d;
    logic [COEF_W-1:0] data_q, data_d, coef;
    logic              accept, last_poly;

    // One shared converter: high nibble comes from the latched byte, low nibble straight from the bus
    assign nib = hi_q ? nib_q : byte_data_i[3:0];

    cbd_coef_unit #(.Q(Q), .COEF_W(COEF_W)) u_coef (
        .nib_i  (nib),
        .coef_o (coef)
    );

    assign byte_ready_o = (state_q == STREAM) && !hi_q && (cnt_q < 8'(CBD_BYTES));
    assign accept       = byte_valid_i && byte_ready_o;
    assign last_poly    = 32'(poly_q) + 32'd1 == 32'(num_q);
    assign busy_o       = state_q != IDLE;
    assign done_o       = state_q == DONE;
    assign prf_req_o    = (state_q == REQ) && (num_q != '0);
    assign prf_nonce_o  = nonce_q;
    assign coef_we_o    = we_q;
    assign coef_poly_o  = cpoly_q;
    assign coef_addr_o  = addr_q;
    assign coef_data_o  = data_q;

    // Next-state and datapath: low coef on accept, high coef the following cycle
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        poly_d  = poly_q;
        nonce_d = nonce_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        nib_d   = nib_q;
        we_d    = 1'b0;
        cpoly_d = cpoly_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            IDLE: if (start_i) begin
                num_d   = num_poly_i;
                nonce_d = nonce_base_i;
                poly_d  = '0;
                cnt_d   = '0;
                state_d = REQ;
            end
            REQ: state_d = (num_q == '0) ? DONE : (prf_ack_i ? STREAM : REQ);
            STREAM: if (hi_q) begin
                we_d   = 1'b1;
                addr_d = addr_q | AW'(1);
                data_d = coef;
                hi_d   = 1'b0;
                cnt_d  = cnt_q + 8'd1;
                if (cnt_q == 8'(CBD_BYTES - 1)) state_d = last_poly ? DONE : NEXT;
            end else if (accept) begin
                we_d    = 1'b1;
                cpoly_d = poly_q;
                addr_d  = {cnt_q[AW-2:0], 1'b0};
                data_d  = coef;
                hi_d    = 1'b1;
                nib_d   = byte_data_i[7:4];
            end
            NEXT: begin
                poly_d  = poly_q + PW'(1);
                nonce_d = nonce_q + 8'd1;
                cnt_d   = '0;
                state_d = REQ;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously so a reset aborts a run at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            num_q   <= '0;
            poly_q  <= '0;
            nonce_q <= '0;
            cnt_q   <= '0;
            hi_q    <= 1'b0;
            nib_q   <= '0;
            we_q    <= 1'b0;
            cpoly_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            poly_q  <= poly_d;
            nonce_q <= nonce_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            nib_q   <= nib_d;
            we_q    <= we_d;
            cpoly_q <= cpoly_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_cbd_sample_ctrl.sv
// tb_cbd_sample_ctrl: directed/randomized bench for cbd_sample_ctrl against a coefficient-list model
module tb_cbd_sample_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic [7:0]  nonce_base_i = '0;
    logic [2:0]  num_poly_i = '0;
    logic        busy_o, done_o, prf_req_o, prf_ack_i = 1'b0;
    logic [7:0]  prf_nonce_o;
    logic        byte_valid_i = 1'b0;
    logic [7:0]  byte_data_i = '0;
    logic        byte_ready_o, coef_we_o;
    logic [2:0]  coef_poly_o;
    logic [7:0]  coef_addr_o;
    logic [11:0] coef_data_o;

    cbd_sample_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .nonce_base_i(nonce_base_i),
        .num_poly_i(num_poly_i), .busy_o(busy_o), .done_o(done_o), .prf_req_o(prf_req_o),
        .prf_nonce_o(prf_nonce_o), .prf_ack_i(prf_ack_i), .byte_valid_i(byte_valid_i),
        .byte_data_i(byte_data_i), .byte_ready_o(byte_ready_o), .coef_we_o(coef_we_o),
        .coef_poly_o(coef_poly_o), .coef_addr_o(coef_addr_o), .coef_data_o(coef_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {int p; int a; int d; int cyc;} wr_t;
    wr_t wr_q[$];
    wr_t exp_q[$];
    int  checks = 0, failures = 0;
    int  cyc = 0, done_cnt = 0, done_cyc = 0;
    bit  prev_acc = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Coefficient for one nibble from the binomial rule, then the output encoding
    function automatic int cbd_map(input logic [3:0] n);
        int c;
        c = (int'(n[0]) + int'(n[1])) - (int'(n[2]) + int'(n[3]));
`ifdef CBD_MODQ_EN
        return c < 0 ? c + 3329 : c;
`else
        return c & 32'hFFF;
`endif
    endfunction

    always @(posedge clk) cyc++;

    // Observer: capture every write, count done pulses, ready must drop after an accept
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_acc) chk("ready_low_after_accept", byte_ready_o, 0);
            prev_acc = byte_valid_i && byte_ready_o;
            if (coef_we_o) wr_q.push_back('{int'(coef_poly_o), int'(coef_addr_o), int'(coef_data_o), cyc});
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else prev_acc = 1'b0;
    end

    task automatic do_run(input int num, input logic [7:0] nb, input int gap, input int mode,
                          input bit disturb, input int rst_poly, input int rst_byte, output bit aborted);
        logic [7:0] tbl [3] = '{8'hEF, 8'hC0, 8'h03};
        logic [7:0] b;
        bit acc;
        int n;
        wr_q.delete();
        exp_q.delete();
        done_cnt = 0;
        aborted  = 1'b0;
        @(posedge clk); #1;
        start_i = 1'b1; nonce_base_i = nb; num_poly_i = 3'(num);
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int p = 0; p < num; p++) begin
            n = 0;
            while (!prf_req_o && n < 20) begin
                @(posedge clk); #1; n++;
            end
            chk("prf_req", prf_req_o, 1);
            if (!prf_req_o) begin aborted = 1'b1; return; end
            chk("prf_nonce", prf_nonce_o, (int'(nb) + p) & 255);
            for (int w = 0; w < 3; w++) begin
                byte_valid_i = disturb;
                byte_data_i  = 8'($urandom);
                #1 chk("ready_low_in_req", byte_ready_o, 0);
                @(posedge clk); #1;
                chk("req_held", prf_req_o, 1);
            end
            byte_valid_i = 1'b0;
            prf_ack_i = 1'b1;
            @(posedge clk); #1;
            prf_ack_i = 1'b0;
            for (int k = 0; k < 128; k++) begin
                b = (mode == 1) ? 8'h00 : (mode == 2 && k < 3) ? tbl[k] : 8'($urandom);
                if (p == rst_poly && k == rst_byte) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_busy", busy_o, 0);
                    chk("rst_done", done_o, 0);
                    chk("rst_req", prf_req_o, 0);
                    chk("rst_ready", byte_ready_o, 0);
                    chk("rst_we", coef_we_o, 0);
                    chk("rst_outs", {coef_poly_o, coef_addr_o, coef_data_o, prf_nonce_o}, 0);
                    byte_valid_i = 1'b0;
                    @(posedge clk); #1;
                    rst_n = 1'b1;
                    aborted = 1'b1;
                    return;
                end
                exp_q.push_back('{p, 2 * k, cbd_map(b[3:0]), 0});
                exp_q.push_back('{p, 2 * k + 1, cbd_map(b[7:4]), 0});
                byte_data_i = b;
                acc = 1'b0;
                n = 0;
                start_i = disturb && k == 20;
                while (!acc && n < 100) begin
                    byte_valid_i = $urandom_range(99) >= gap;
                    @(negedge clk);
                    acc = byte_valid_i && byte_ready_o;
                    @(posedge clk); #1;
                    start_i = 1'b0;
                    n++;
                end
                if (!acc) begin
                    chk("accept_timeout", 0, 1);
                    byte_valid_i = 1'b0;
                    aborted = 1'b1;
                    return;
                end
            end
            byte_valid_i = 1'b0;
        end
        n = 0;
        while (busy_o && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("busy_end", busy_o, 0);
        chk("done_count", done_cnt, 1);
        chk("n_writes", wr_q.size(), exp_q.size());
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            chk("wr_poly", wr_q[i].p, exp_q[i].p);
            chk("wr_addr", wr_q[i].a, exp_q[i].a);
            chk("wr_data", wr_q[i].d, exp_q[i].d);
            if (i > 0) chk("one_write_per_cycle", wr_q[i].cyc > wr_q[i-1].cyc, 1);
        end
        if (wr_q.size() > 0) chk("done_after_last_coef", done_cyc >= wr_q[wr_q.size()-1].cyc, 1);
    endtask

    initial begin
        bit ab;
`ifdef CBD_MODQ_EN
        int t1 [6] = '{0, 3328, 0, 3327, 2, 0};
`else
        int t1 [6] = '{0, 4095, 0, 4094, 2, 0};
`endif
        #12;
        chk("reset_busy", busy_o, 0);
        chk("reset_outs", {done_o, prf_req_o, byte_ready_o, coef_we_o, coef_addr_o, coef_data_o}, 0);
        rst_n = 1'b1;
        // 1: single poly, known leading bytes
        do_run(1, 8'h05, 0, 2, 1'b0, -1, -1, ab);
        for (int i = 0; i < 6 && i < wr_q.size(); i++) chk("t1_coef", wr_q[i].d, t1[i]);
        // 2: three polys, zero bytes, nonce wraps
        do_run(3, 8'hFE, 0, 1, 1'b0, -1, -1, ab);
        chk("t2_last_poly", wr_q.size() > 0 ? wr_q[wr_q.size()-1].p : -1, 2);
        // 3: 50% valid gaps
        do_run(1, 8'h33, 50, 0, 1'b0, -1, -1, ab);
        // 4: zero polys
        @(posedge clk); #1;
        start_i = 1'b1; num_poly_i = 3'd0;
        @(negedge clk);
        chk("np0_c0_busy", busy_o, 0);
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("np0_c1", {busy_o, done_o, prf_req_o}, 3'b100);
        @(negedge clk);
        chk("np0_c2", {busy_o, done_o, prf_req_o}, 3'b110);
        @(negedge clk);
        chk("np0_c3", {busy_o, done_o, prf_req_o}, 3'b000);
        // 5: reset during poly 1 byte 40, then fresh run
        do_run(2, 8'h80, 20, 0, 1'b0, 1, 40, ab);
        chk("t5_aborted", ab, 1);
        do_run(1, 8'h10, 0, 0, 1'b0, -1, -1, ab);
        chk("t5_first_wr", wr_q.size() > 0 ? {wr_q[0].p, wr_q[0].a} : -1, 0);
        // 6: start during STREAM and valid during REQ ignored
        do_run(2, 8'h42, 30, 0, 1'b1, -1, -1, ab);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
